// File: rtl/sd_audio_pkg.sv
// Shared types and constants for the SD-to-audio-RAM sector scheduler.
package sd_audio_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FAULT = 3'd5
  } sched_state_e;

  localparam int unsigned SEC_BYTES  = 512;
  localparam int unsigned HALF_BYTES = 4096;

  localparam logic [31:0] DEF_START_SEC = 32'd16448;
  localparam logic [31:0] DEF_END_SEC   = 32'd15269887;

  function automatic logic [31:0] next_sec(input logic [31:0] cur,
                                           input logic [31:0] first,
                                           input logic [31:0] last);
    return (cur == last) ? first : cur + 32'd1;
  endfunction

endpackage

// File: rtl/sd_sec_addr_gen.sv
// Sector address counter: resets to START_SEC, wraps from END_SEC back to START_SEC.
module sd_sec_addr_gen
  import sd_audio_pkg::*;
#(
  parameter logic [31:0] START_SEC = DEF_START_SEC,
  parameter logic [31:0] END_SEC   = DEF_END_SEC
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inc_i,
  output logic [31:0] addr_o
);

  logic [31:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (inc_i) addr_d = next_sec(addr_q, START_SEC, END_SEC);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) addr_q <= START_SEC;
    else          addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sd_pingpong_sched.sv
// Ping-pong scheduler: fetches SD sectors into alternating 4 KB RAM halves
// and hands filled halves to the playback side.
module sd_pingpong_sched
  import sd_audio_pkg::*;
#(
  parameter logic [31:0] START_SEC     = DEF_START_SEC,
  parameter logic [31:0] END_SEC       = DEF_END_SEC,
  parameter int unsigned SECS_PER_HALF = HALF_BYTES / SEC_BYTES,
  parameter int unsigned STARTUP_CYC   = 1023,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  output logic        sec_req,
  output logic [31:0] sec_addr,
  output logic        wr_half,
  input  logic        sec_ack,
  input  logic        sec_done,
  input  logic        sec_err,
  input  logic        half_free,
  output logic        play_half,
  output logic        play_en,
  output logic [1:0]  half_valid,
  output logic        underrun,
  output logic [15:0] underrun_cnt,
  output logic        fault
);

  localparam int unsigned CNT_W = $clog2(STARTUP_CYC + 1);
  localparam int unsigned SEC_W = $clog2(SECS_PER_HALF + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             sec_req_q, sec_req_d;
  logic             wr_half_q, wr_half_d;
  logic             fault_q, fault_d;
  logic             addr_inc;
  logic [1:0]       hv_set;

  logic [1:0]       hv_q, hv_d;
  logic             play_half_q, play_half_d;
  logic             play_en_q, play_en_d;
  logic             primed_q, primed_d;
  logic             underrun_q, underrun_d;
  logic [15:0]      ur_cnt_q, ur_cnt_d;
  logic             other_half;

  sd_sec_addr_gen #(
    .START_SEC(START_SEC),
    .END_SEC  (END_SEC)
  ) u_addr (
    .clk_i  (clk_50M),
    .rst_n_i(rst_n),
    .inc_i  (addr_inc),
    .addr_o (sec_addr)
  );

  // sec_req is registered, so it rises one cycle after ISSUE is entered;
  // an ack is only honoured once the request is actually visible.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    sec_cnt_d  = sec_cnt_q;
    retry_d    = retry_q;
    sec_req_d  = 1'b0;
    wr_half_d  = wr_half_q;
    fault_d    = fault_q;
    addr_inc   = 1'b0;
    hv_set     = '0;
    unique case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == CNT_W'(STARTUP_CYC - 1)) state_d = ST_ISSUE;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      ST_ISSUE: begin
        sec_req_d = 1'b1;
        if (sec_req_q && sec_ack) begin
          sec_req_d = 1'b0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (sec_done) begin
          retry_d  = '0;
          addr_inc = 1'b1;
          if (sec_cnt_q == SEC_W'(SECS_PER_HALF - 1)) begin
            hv_set[wr_half_q] = 1'b1;
            wr_half_d         = ~wr_half_q;
            sec_cnt_d         = '0;
            state_d           = ST_CHECK;
          end else begin
            sec_cnt_d = sec_cnt_q + 1'b1;
            state_d   = ST_ISSUE;
          end
        end else if (sec_err) begin
          if (retry_q == RTY_W'(MAX_RETRY)) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_CHECK: state_d = hv_q[wr_half_q] ? ST_HOLD : ST_ISSUE;
      ST_HOLD:  if (!hv_q[wr_half_q]) state_d = ST_ISSUE;
      ST_FAULT: fault_d = 1'b1;
      default:  state_d = ST_WAIT;
    endcase
  end

  assign other_half = ~play_half_q;

  // Clear from half_free is applied before the FSM's set, so a set wins.
  always_comb begin
    hv_d        = hv_q;
    play_half_d = play_half_q;
    play_en_d   = play_en_q;
    primed_d    = primed_q;
    underrun_d  = 1'b0;
    ur_cnt_d    = ur_cnt_q;
    if (half_free && play_en_q) begin
      hv_d[play_half_q] = 1'b0;
      play_half_d       = other_half;
      if (!hv_q[other_half]) begin
        underrun_d = 1'b1;
        play_en_d  = 1'b0;
        if (ur_cnt_q != '1) ur_cnt_d = ur_cnt_q + 16'd1;
      end
    end else if (!primed_q) begin
      if (hv_q == 2'b11) begin
        play_en_d = 1'b1;
        primed_d  = 1'b1;
      end
    end else if (!play_en_q && hv_q[play_half_q]) begin
      play_en_d = 1'b1;
    end
    hv_d = hv_d | hv_set;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      wait_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      retry_q     <= '0;
      sec_req_q   <= 1'b0;
      wr_half_q   <= 1'b0;
      fault_q     <= 1'b0;
      hv_q        <= '0;
      play_half_q <= 1'b0;
      play_en_q   <= 1'b0;
      primed_q    <= 1'b0;
      underrun_q  <= 1'b0;
      ur_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      retry_q     <= retry_d;
      sec_req_q   <= sec_req_d;
      wr_half_q   <= wr_half_d;
      fault_q     <= fault_d;
      hv_q        <= hv_d;
      play_half_q <= play_half_d;
      play_en_q   <= play_en_d;
      primed_q    <= primed_d;
      underrun_q  <= underrun_d;
      ur_cnt_q    <= ur_cnt_d;
    end
  end

  assign sec_req      = sec_req_q;
  assign wr_half      = wr_half_q;
  assign fault        = fault_q;
  assign half_valid   = hv_q;
  assign play_half    = play_half_q;
  assign play_en      = play_en_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ur_cnt_q;

endmodule

// File: tb/tb_sd_pingpong_sched.sv
// Bench for sd_pingpong_sched: default-parameter instance for the startup/prime/
// underrun/error sequences, small-parameter instance for wrap table and random run.
module tb_sd_pingpong_sched;

  localparam logic [31:0] A_START = 32'd16448;
  localparam int          LIM     = 3000;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n_a, rst_n_b, sel;
  logic ack, done, err, free;

  logic        a_req, a_wh, a_ph, a_en, a_ur, a_fault;
  logic [31:0] a_addr;
  logic [1:0]  a_hv;
  logic [15:0] a_urc;
  logic        b_req, b_wh, b_ph, b_en, b_ur, b_fault;
  logic [31:0] b_addr;
  logic [1:0]  b_hv;
  logic [15:0] b_urc;

  logic        req, wh, ph, en, ur, fault;
  logic [31:0] addr;
  logic [1:0]  hv;
  logic [15:0] urc;

  int total = 0;
  int bad   = 0;

  sd_pingpong_sched #(
    .START_SEC(32'd16448), .END_SEC(32'd15269887), .SECS_PER_HALF(8),
    .STARTUP_CYC(1023), .MAX_RETRY(3)
  ) dut_a (
    .clk_50M(clk), .rst_n(rst_n_a), .sec_req(a_req), .sec_addr(a_addr), .wr_half(a_wh),
    .sec_ack(ack && !sel), .sec_done(done && !sel), .sec_err(err && !sel),
    .half_free(free && !sel), .play_half(a_ph), .play_en(a_en), .half_valid(a_hv),
    .underrun(a_ur), .underrun_cnt(a_urc), .fault(a_fault)
  );

  sd_pingpong_sched #(
    .START_SEC(32'd10), .END_SEC(32'd13), .SECS_PER_HALF(2),
    .STARTUP_CYC(4), .MAX_RETRY(3)
  ) dut_b (
    .clk_50M(clk), .rst_n(rst_n_b), .sec_req(b_req), .sec_addr(b_addr), .wr_half(b_wh),
    .sec_ack(ack && sel), .sec_done(done && sel), .sec_err(err && sel),
    .half_free(free && sel), .play_half(b_ph), .play_en(b_en), .half_valid(b_hv),
    .underrun(b_ur), .underrun_cnt(b_urc), .fault(b_fault)
  );

  assign req   = sel ? b_req   : a_req;
  assign addr  = sel ? b_addr  : a_addr;
  assign wh    = sel ? b_wh    : a_wh;
  assign ph    = sel ? b_ph    : a_ph;
  assign en    = sel ? b_en    : a_en;
  assign hv    = sel ? b_hv    : a_hv;
  assign ur    = sel ? b_ur    : a_ur;
  assign urc   = sel ? b_urc   : a_urc;
  assign fault = sel ? b_fault : a_fault;

  typedef struct {
    bit          free_before;
    int          n_err;
    logic [31:0] addr;
    logic        wh;
    logic [1:0]  hv;
    logic        ph;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic rq, input logic [31:0] ad, input logic w,
                                       input logic p, input logic e, input logic [1:0] v,
                                       input logic u, input logic [15:0] uc, input logic f);
    return {8'h00, rq, ad, w, p, e, v, u, uc, f};
  endfunction

  function automatic logic [63:0] dut_out();
    return pack(req, addr, wh, ph, en, hv, ur, urc, fault);
  endfunction

  task automatic wait_req(output int n);
    n = 0;
    while (!req && n < LIM) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Acts as the SD reader for one sector: n_err failed attempts, then done if ok.
  task automatic serve(input int n_err, input bit ok, input logic [31:0] ea,
                       input logic ew, input string nm);
    int n;
    int iters;
    iters = n_err + (ok ? 1 : 0);
    for (int k = 0; k < iters; k++) begin
      wait_req(n);
      chk({nm, "_req"}, 64'(req), 64'd1);
      chk({nm, "_addr"}, 64'(addr), 64'(ea));
      chk({nm, "_wh"}, 64'(wh), 64'(ew));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk({nm, "_drop"}, 64'(req), 64'd0);
      @(negedge clk);
      if (k < n_err) err = 1'b1;
      else           done = 1'b1;
      @(negedge clk);
      err  = 1'b0;
      done = 1'b0;
    end
  endtask

  task automatic pulse_free();
    free = 1'b1;
    @(negedge clk);
    free = 1'b0;
  endtask

  task automatic run_random();
    bit [1:0]    m_hv = 2'b00;
    bit          m_ph = 1'b0, m_en = 1'b0, m_primed = 1'b0, m_ur = 1'b0;
    logic [15:0] m_urc = 16'h0;
    int          n_done = 0, tries = 0, phase = 0, dly = 0;
    bit          a_in, d_in, e_in, f_in, o_en, o_ph;
    bit [1:0]    o_hv;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_state", 64'({ph, en, hv, ur, urc, fault}),
          64'({m_ph, m_en, m_hv, m_ur, m_urc, 1'b0}));
      a_in = 1'b0; d_in = 1'b0; e_in = 1'b0;
      if (phase == 0 && req) begin
        chk("rnd_addr", 64'(addr), 64'(32'd10 + 32'(n_done % 4)));
        chk("rnd_wh", 64'(wh), 64'((n_done / 2) % 2));
        chk("rnd_fullwr", 64'(m_hv[(n_done / 2) % 2]), 64'd0);
        if ($urandom % 2 == 0) begin
          a_in  = 1'b1;
          phase = 1;
          dly   = $urandom_range(3, 1);
        end
      end else if (phase == 1) begin
        dly--;
        if (dly == 0) begin
          phase = 0;
          if (tries < 3 && $urandom % 6 == 0) begin e_in = 1'b1; tries++; end
          else begin d_in = 1'b1; tries = 0; end
        end
      end
      f_in = ($urandom % 5 == 0);
      ack = a_in; done = d_in; err = e_in; free = f_in;
      // expected effect of this edge
      o_hv = m_hv; o_ph = m_ph; o_en = m_en;
      m_ur = 1'b0;
      if (f_in && o_en) begin
        m_hv[o_ph] = 1'b0;
        m_ph = !o_ph;
        if (!o_hv[!o_ph]) begin
          m_ur = 1'b1;
          m_en = 1'b0;
          if (m_urc != 16'hFFFF) m_urc = m_urc + 16'd1;
        end
      end else if (!m_primed) begin
        if (o_hv == 2'b11) begin m_en = 1'b1; m_primed = 1'b1; end
      end else if (!o_en && o_hv[o_ph]) begin
        m_en = 1'b1;
      end
      if (d_in) begin
        n_done++;
        if (n_done % 2 == 0) m_hv[((n_done - 1) / 2) % 2] = 1'b1;
      end
      @(negedge clk);
    end
    ack = 1'b0; done = 1'b0; err = 1'b0; free = 1'b0;
    chk("rnd_progress", 64'(n_done >= 100), 64'd1);
  endtask

  initial begin
    int n;
    bit seen;
    tbl[0] = '{1'b0, 0, 32'd10, 1'b0, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 0, 32'd11, 1'b0, 2'b01, 1'b0};
    tbl[2] = '{1'b0, 1, 32'd12, 1'b1, 2'b01, 1'b0};
    tbl[3] = '{1'b0, 0, 32'd13, 1'b1, 2'b11, 1'b0};
    tbl[4] = '{1'b1, 0, 32'd10, 1'b0, 2'b10, 1'b1};
    tbl[5] = '{1'b0, 0, 32'd11, 1'b0, 2'b11, 1'b1};

    sel = 1'b0; ack = 1'b0; done = 1'b0; err = 1'b0; free = 1'b0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_a", dut_out(), pack(1'b0, A_START, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0));

    rst_n_a = 1'b1;
    wait_req(n);
    chk("startup_lat", 64'(n), 64'd1024);
    chk("startup_addr", 64'(addr), 64'(A_START));
    chk("startup_wh", 64'(wh), 64'd0);

    for (int i = 0; i < 16; i++) begin
      serve(0, 1'b1, A_START + 32'(i), 1'(i / 8), "prime");
      if (i == 7) chk("prime_hv01", 64'(hv), 64'd1);
    end
    chk("prime_hv11", 64'(hv), 64'd3);
    chk("prime_en0", 64'(en), 64'd0);
    @(negedge clk);
    chk("prime_en1", 64'(en), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req) seen = 1'b1;
      @(negedge clk);
    end
    chk("hold_noreq", 64'(seen), 64'd0);
    chk("hold_addr", 64'(addr), 64'(A_START + 32'd16));

    pulse_free();
    chk("free1", 64'({hv, ph, ur, en}), 64'({2'b10, 1'b1, 1'b0, 1'b1}));
    wait_req(n);
    chk("resume_req", 64'(req), 64'd1);
    chk("resume_addr", 64'(addr), 64'(A_START + 32'd16));
    chk("resume_wh", 64'(wh), 64'd0);

    pulse_free();
    chk("ur_pulse", 64'({ur, urc, en, hv, ph}), 64'({1'b1, 16'd1, 1'b0, 2'b00, 1'b0}));
    @(negedge clk);
    chk("ur_single", 64'(ur), 64'd0);
    for (int i = 0; i < 8; i++) serve(0, 1'b1, A_START + 32'd16 + 32'(i), 1'b0, "refill");
    chk("refill_hv", 64'(hv), 64'd1);
    chk("refill_en0", 64'(en), 64'd0);
    @(negedge clk);
    chk("refill_en1", 64'(en), 64'd1);
    chk("refill_urc", 64'(urc), 64'd1);

    rst_n_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;
    serve(3, 1'b1, A_START, 1'b0, "err3");
    serve(4, 1'b0, A_START + 32'd1, 1'b0, "err4");
    chk("fault_set", 64'(fault), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req || !fault) seen = 1'b1;
      @(negedge clk);
    end
    chk("fault_hold", 64'(seen), 64'd0);
    rst_n_a = 1'b0;
    @(negedge clk);
    chk("rst_fault", dut_out(), pack(1'b0, A_START, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0));
    rst_n_a = 1'b1;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("post_rst_done", dut_out(), pack(1'b0, A_START, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0));

    sel = 1'b1;
    rst_n_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].free_before) begin
        repeat (2) @(negedge clk);
        pulse_free();
      end
      serve(tbl[i].n_err, 1'b1, tbl[i].addr, tbl[i].wh, "tbl");
      chk("tbl_hv", 64'(hv), 64'(tbl[i].hv));
      chk("tbl_ph", 64'(ph), 64'(tbl[i].ph));
    end

    rst_n_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_b", dut_out(), pack(1'b0, 32'd10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0));
    rst_n_b = 1'b1;
    run_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_pingpong_sched.md
Name: sd_pingpong_sched

Overview:
- Sequences SD sector reads into the 8 KB byte RAM used for WAV playback.
- The RAM is treated as two 4 KB halves (ping-pong); each half holds SECS_PER_HALF sectors of 512 bytes.
- The block decides which sector to fetch and which half to fill, tracks the fill state of each half, and tells the playback side when a half is ready.
- It sits between the SD sector reader and the audio-side RAM reader, on the 50 MHz domain.

Parameters:
- START_SEC, 32'd16448, first audio sector; also the wrap target.
- END_SEC, 32'd15269887, last audio sector; after it, addressing wraps to START_SEC.
- SECS_PER_HALF, 8, sectors per 4 KB half.
- STARTUP_CYC, 1023, wait cycles after reset before the first request (SD init settle).
- MAX_RETRY, 3, retries of one sector after sec_err before entering fault.

Ports:
- clk_50M  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sec_req  out  1  sector read request; level, held until sec_ack.
- sec_addr  out  32  sector number; stable while sec_req=1.
- wr_half  out  1  RAM half being filled; the writer uses {wr_half, byte_idx[11:0]}.
- sec_ack  in  1  one-cycle pulse: reader accepted the request.
- sec_done  in  1  one-cycle pulse: all 512 bytes written.
- sec_err  in  1  one-cycle pulse: read failed (replaces sec_done).
- half_free  in  1  one-cycle pulse from the playback side: finished consuming play_half.
- play_half  out  1  half the playback side must read.
- play_en  out  1  playback allowed.
- half_valid  out  2  bit i = half i full and unread.
- underrun  out  1  one-cycle pulse: playback switched to a non-full half.
- underrun_cnt  out  16  saturating count of underrun pulses.
- fault  out  1  sticky; retries exhausted.

Behaviour:
- Reset values (rst_n=0 at an edge): sec_req=0, sec_addr=START_SEC, wr_half=0, play_half=0, play_en=0, half_valid=2'b00, underrun=0, underrun_cnt=0, fault=0, state=WAIT, startup counter=0, sector-in-half count=0, retry=0.
- A reset mid-transfer abandons it; sec_done/sec_err arriving after reset are ignored.
- WAIT: the counter increments each cycle. When it reaches STARTUP_CYC-1, move to ISSUE on the next cycle.
- ISSUE: sec_req=1. On sec_ack, sec_req drops in the same cycle's registered update, then go to BUSY.
- BUSY, on sec_done:
  - Clear retry.
  - sec_addr <= (sec_addr==END_SEC) ? START_SEC : sec_addr+1.
  - Increment the sector-in-half count.
  - If the count reaches SECS_PER_HALF: set half_valid[wr_half], toggle wr_half, clear the count, go to CHECK. Otherwise go to ISSUE.
- BUSY, on sec_err:
  - retry+1 and return to ISSUE with the same sec_addr.
  - If retry==MAX_RETRY, go to FAULT instead (fault=1, sec_req=0). Only rst_n exits FAULT.
- CHECK / HOLD: if half_valid[wr_half]==0, go to ISSUE; else go to HOLD. HOLD waits until that bit clears, then goes to ISSUE. At most one cycle of CHECK latency.
- Priming: play_en rises the cycle after half_valid==2'b11 first occurs. It stays 1 until reset, except that it drops during an underrun.
- half_free (ignored unless play_en=1):
  - Clear half_valid[play_half] and toggle play_half.
  - If half_valid[~play_half] was 0 at that edge: pulse underrun, increment underrun_cnt (saturating at 16'hFFFF), and drop play_en.
  - play_en re-rises the cycle after half_valid[play_half] becomes 1.
- Simultaneous set and clear of the same half_valid bit in one cycle (only possible under misuse): the set wins.
- Simultaneous half-completion and half_free on different halves: both take effect in the same cycle.
- sec_ack, sec_done and sec_err outside their expected state are ignored.
- No combinational paths from inputs to outputs.

Decomposition:
- Shared package sd_audio_pkg holds:
  - state encoding constants: WAIT, ISSUE, BUSY, CHECK, HOLD, FAULT (3-bit);
  - SEC_BYTES=512 and HALF_BYTES=4096;
  - default START_SEC/END_SEC.
- One sub-module is natural: sd_sec_addr_gen (wrapping sector counter with load and increment). Everything else stays in a single always-block FSM plus the playback-side tracker.

Test Plan:
- Startup: hold rst_n=0 for 5 cycles, then release. sec_req must rise exactly STARTUP_CYC+1 cycles later with sec_addr=16448 and wr_half=0.
- Prime: ack and done 16 sectors with no half_free. Expect:
  - half_valid goes 01, then 11;
  - play_en=1 one cycle after 11;
  - the block in HOLD with sec_req=0 and sec_addr=16464.
- Steady state: after priming, pulse half_free. Expect half_valid=10, play_half=1, no underrun; sec_req resumes for sector 16464 with wr_half=0.
- Wrap: START_SEC=10, END_SEC=13, SECS_PER_HALF=2. After 6 sector completions, sec_addr runs 10,11,12,13,10,11.
- Underrun: prime, then pulse half_free twice without any sec_done. Expect one underrun pulse, underrun_cnt=1, play_en=0. Complete 8 sectors: play_en re-rises one cycle after the half_valid bit sets.
- Error and reset: return sec_err 3 times on sector 16448, then sec_done; sec_addr must advance to 16449. Then return sec_err 4 times: fault=1 and sec_req stays 0. Assert rst_n=0: all outputs return to reset values.
